// File: rtl/vector_memory_sequencer_if.sv
// Byte-wide memory port between the vector memory sequencer and its memory.
// Read data is returned one cycle after the address is presented.
interface vector_memory_sequencer_if;
    logic [15:0] mem_address;
    logic [7:0]  mem_write_data;
    logic        mem_write_enable;
    logic [7:0]  mem_read_data;

    modport master (
        output mem_address,
        output mem_write_data,
        output mem_write_enable,
        input  mem_read_data
    );

    modport slave (
        input  mem_address,
        input  mem_write_data,
        input  mem_write_enable,
        output mem_read_data
    );
endinterface

// File: rtl/vector_memory_sequencer.sv
// Vector memory sequencer: serialises scalar and vector loads/stores from the
// memory stage onto a byte-wide memory port, stalling the pipeline meanwhile.
// Optional macro VMEM_ADDR_CHECK_EN rejects vector requests whose byte range
// would run past 16'hFFFF (addr_error pulse); without it addresses wrap.
module vector_memory_sequencer #(
    parameter int VECTOR_BYTES = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        write_memory_enable_a_memory,
    input  logic                        write_memory_enable_b_memory,
    input  logic                        load_scalar_memory,
    input  logic                        load_vector_memory,
    input  logic [15:0]                 srcA_memory,
    input  logic [15:0]                 srcB_memory,
    input  logic [8*VECTOR_BYTES-1:0]   vector_srcB_memory,
    vector_memory_sequencer_if.master   mem_bus,
    output logic                        stall,
    output logic                        done_memory,
    output logic [7:0]                  load_data_memory,
    output logic [8*VECTOR_BYTES-1:0]   vector_load_data_memory,
    output logic                        addr_error
);
    localparam int VW = 8 * VECTOR_BYTES;
    localparam int CW = $clog2(VECTOR_BYTES) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(VECTOR_BYTES - 1);
`ifdef VMEM_ADDR_CHECK_EN
    localparam logic [15:0] MAX_BASE = 16'(65535 - (VECTOR_BYTES - 1));
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SREAD  = 3'd1,
        VSTORE = 3'd2,
        VLOAD  = 3'd3,
        VLAST  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     base_q, base_d;
    logic [VW-1:0]   vdata_q, vdata_d;
    logic [VW-1:0]   buf_q, buf_d;
    logic [VW-1:0]   vload_q, vload_d;
    logic [7:0]      ldata_q, ldata_d;

    logic [15:0]     addr_s;
    logic [7:0]      wdata_s;
    logic            we_s;
    logic            stall_s;
    logic            done_s;
    logic            aerr_s;
    logic            range_bad_s;
    logic            unused_srcb_hi_s;

    // Only the low byte of the scalar store operand is written.
    assign unused_srcb_hi_s = ^srcB_memory[15:8];

    // Next-state, datapath capture and memory-port decode for the sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        vdata_d = vdata_q;
        buf_d   = buf_q;
        vload_d = vload_q;
        ldata_d = ldata_q;
        addr_s  = 16'h0000;
        wdata_s = 8'h00;
        we_s    = 1'b0;
        stall_s = 1'b0;
        done_s  = 1'b0;
        aerr_s  = 1'b0;
`ifdef VMEM_ADDR_CHECK_EN
        range_bad_s = (write_memory_enable_b_memory || load_vector_memory) &&
                      (srcA_memory > MAX_BASE);
`else
        range_bad_s = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (range_bad_s) begin
                    aerr_s = 1'b1;
                end else if (write_memory_enable_b_memory) begin
                    addr_s  = srcA_memory;
                    wdata_s = vector_srcB_memory[7:0];
                    we_s    = 1'b1;
                    stall_s = 1'b1;
                    base_d  = srcA_memory;
                    vdata_d = vector_srcB_memory;
                    cnt_d   = CW'(1);
                    state_d = VSTORE;
                end else if (load_vector_memory) begin
                    addr_s  = srcA_memory;
                    stall_s = 1'b1;
                    base_d  = srcA_memory;
                    cnt_d   = CW'(1);
                    state_d = VLOAD;
                end else if (write_memory_enable_a_memory) begin
                    addr_s  = srcA_memory;
                    wdata_s = srcB_memory[7:0];
                    we_s    = 1'b1;
                    done_s  = 1'b1;
                end else if (load_scalar_memory) begin
                    addr_s  = srcA_memory;
                    stall_s = 1'b1;
                    base_d  = srcA_memory;
                    state_d = SREAD;
                end else begin
                    state_d = IDLE;
                end
            end
            SREAD: begin
                addr_s  = base_q;
                ldata_d = mem_bus.mem_read_data;
                done_s  = 1'b1;
                state_d = IDLE;
            end
            VSTORE: begin
                addr_s  = base_q + 16'(cnt_q);
                wdata_s = vdata_q[8*int'(cnt_q) +: 8];
                we_s    = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    done_s  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    stall_s = 1'b1;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            VLOAD: begin
                // Data returning now belongs to the address issued last cycle.
                addr_s  = base_q + 16'(cnt_q);
                stall_s = 1'b1;
                buf_d[8*(int'(cnt_q) - 1) +: 8] = mem_bus.mem_read_data;
                if (cnt_q == LAST_IDX) begin
                    state_d = VLAST;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            VLAST: begin
                // Publish the whole vector at once so no partial result leaks.
                addr_s  = base_q;
                vload_d = {mem_bus.mem_read_data, buf_q[VW-9:0]};
                done_s  = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Output stage: reset silences the memory port and handshakes immediately.
    always_comb begin
        if (reset) begin
            mem_bus.mem_address      = 16'h0000;
            mem_bus.mem_write_data   = 8'h00;
            mem_bus.mem_write_enable = 1'b0;
            stall                    = 1'b0;
            done_memory              = 1'b0;
            addr_error               = 1'b0;
        end else begin
            mem_bus.mem_address      = addr_s;
            mem_bus.mem_write_data   = wdata_s;
            mem_bus.mem_write_enable = we_s;
            stall                    = stall_s;
            done_memory              = done_s;
            addr_error               = aerr_s;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= 16'h0000;
            vdata_q <= '0;
            buf_q   <= '0;
            vload_q <= '0;
            ldata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            vdata_q <= vdata_d;
            buf_q   <= buf_d;
            vload_q <= vload_d;
            ldata_q <= ldata_d;
        end
    end

    assign load_data_memory        = ldata_q;
    assign vector_load_data_memory = vload_q;
endmodule

// File: tb/tb_vector_memory_sequencer.sv
// Randomised self-checking bench for vector_memory_sequencer. A byte memory
// sits on the slave side; a separate shadow memory holds the bench's own view
// of what has been stored, from which all load expectations are derived.
module tb_vector_memory_sequencer;
    localparam int VB = 16;
    localparam int VW = 8 * VB;

    logic          clk = 1'b0;
    logic          reset;
    logic          wa, wb, ls, lv;
    logic [15:0]   src_a, src_b;
    logic [VW-1:0] vsrc_b;
    logic          stall, done_m, aerr;
    logic [7:0]    ld;
    logic [VW-1:0] vld;

    logic [7:0]    mem     [0:65535];
    logic [7:0]    ref_mem [0:65535];
    int            total = 0;
    int            bad   = 0;
    logic [7:0]    exp_ld;
    logic [VW-1:0] exp_vl;
    logic [15:0]   last_s, last_v;

    vector_memory_sequencer_if bus ();

    vector_memory_sequencer #(.VECTOR_BYTES(VB)) dut (
        .clk(clk), .reset(reset),
        .write_memory_enable_a_memory(wa), .write_memory_enable_b_memory(wb),
        .load_scalar_memory(ls), .load_vector_memory(lv),
        .srcA_memory(src_a), .srcB_memory(src_b), .vector_srcB_memory(vsrc_b),
        .mem_bus(bus), .stall(stall), .done_memory(done_m),
        .load_data_memory(ld), .vector_load_data_memory(vld), .addr_error(aerr)
    );

    always #5 clk = ~clk;

    // Byte memory with one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_write_enable) mem[bus.mem_address] <= bus.mem_write_data;
        bus.mem_read_data <= mem[bus.mem_address];
    end

    task automatic clr();
        wa = 1'b0; wb = 1'b0; ls = 1'b0; lv = 1'b0;
        src_a = 16'h0000; src_b = 16'h0000; vsrc_b = '0;
    endtask

    task automatic junk();
        {wa, wb, ls, lv} = 4'($urandom);
        src_a  = 16'($urandom);
        src_b  = 16'($urandom);
        vsrc_b = {$urandom, $urandom, $urandom, $urandom};
    endtask

    function automatic logic [15:0] rand_base();
`ifdef VMEM_ADDR_CHECK_EN
        return 16'($urandom_range(0, 65535 - (VB - 1)));
`else
        return 16'($urandom);
`endif
    endfunction

    task automatic test_reset();
        reset = 1'b1; clr(); wa = 1'b1; src_a = 16'h1234; src_b = 16'h00FF;
        @(negedge clk); #1;
        total++; if (bus.mem_write_enable !== 1'b0) begin bad++; $display("FAIL rst_we got=%0b want=0", bus.mem_write_enable); end
        total++; if (done_m !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b want=0", done_m); end
        @(negedge clk); clr();
        @(negedge clk); reset = 1'b0; #1;
        total++; if (ld !== 8'h00) begin bad++; $display("FAIL rst_ld got=%h want=00", ld); end
        total++; if (vld !== '0) begin bad++; $display("FAIL rst_vld got=%h want=0", vld); end
        total++; if ({done_m, aerr, stall, bus.mem_write_enable} !== 4'b0000) begin bad++; $display("FAIL rst_flags got=%b want=0000", {done_m, aerr, stall, bus.mem_write_enable}); end
        total++; if ({bus.mem_address, bus.mem_write_data} !== 24'h000000) begin bad++; $display("FAIL rst_bus got=%h want=000000", {bus.mem_address, bus.mem_write_data}); end
        exp_ld = 8'h00; exp_vl = '0;
    endtask

    task automatic test_scalar_store(input logic [15:0] a, input logic [15:0] d, input logic extra_ls);
        @(negedge clk); clr(); wa = 1'b1; ls = extra_ls; src_a = a; src_b = d; #1;
        total++; if (bus.mem_write_enable !== 1'b1) begin bad++; $display("FAIL ss_we got=%0b want=1", bus.mem_write_enable); end
        total++; if (bus.mem_address !== a) begin bad++; $display("FAIL ss_addr got=%h want=%h", bus.mem_address, a); end
        total++; if (bus.mem_write_data !== d[7:0]) begin bad++; $display("FAIL ss_data got=%h want=%h", bus.mem_write_data, d[7:0]); end
        total++; if ({stall, done_m} !== 2'b01) begin bad++; $display("FAIL ss_hs got=%b want=01", {stall, done_m}); end
        ref_mem[a] = d[7:0]; last_s = a;
        @(negedge clk); clr(); #1;
        total++; if ({done_m, bus.mem_write_enable, stall} !== 3'b000) begin bad++; $display("FAIL ss_after got=%b want=000", {done_m, bus.mem_write_enable, stall}); end
    endtask

    task automatic test_scalar_load(input logic [15:0] a);
        logic [7:0] e;
        e = ref_mem[a];
        @(negedge clk); clr(); ls = 1'b1; src_a = a; #1;
        total++; if (bus.mem_address !== a) begin bad++; $display("FAIL sl_addr got=%h want=%h", bus.mem_address, a); end
        total++; if ({stall, done_m, bus.mem_write_enable} !== 3'b100) begin bad++; $display("FAIL sl_c0 got=%b want=100", {stall, done_m, bus.mem_write_enable}); end
        @(negedge clk); junk(); #1;
        total++; if ({stall, done_m, bus.mem_write_enable} !== 3'b010) begin bad++; $display("FAIL sl_c1 got=%b want=010", {stall, done_m, bus.mem_write_enable}); end
        total++; if (ld !== exp_ld) begin bad++; $display("FAIL sl_hold got=%h want=%h", ld, exp_ld); end
        @(negedge clk); clr(); #1;
        total++; if (ld !== e) begin bad++; $display("FAIL sl_data got=%h want=%h", ld, e); end
        total++; if (done_m !== 1'b0) begin bad++; $display("FAIL sl_done2 got=%0b want=0", done_m); end
        exp_ld = e;
    endtask

    task automatic test_vector_store(input logic [15:0] base, input logic [VW-1:0] data,
                                     input logic [2:0] extra, input logic use_junk);
        logic [15:0] ea;
        int stalls;
        @(negedge clk); clr(); wb = 1'b1; {lv, ls, wa} = extra; src_a = base; vsrc_b = data;
        src_b = 16'($urandom); #1;
        total++; if ({bus.mem_write_enable, stall, done_m, aerr} !== 4'b1100) begin bad++; $display("FAIL vs_c0 got=%b want=1100", {bus.mem_write_enable, stall, done_m, aerr}); end
        total++; if ({bus.mem_address, bus.mem_write_data} !== {base, data[7:0]}) begin bad++; $display("FAIL vs_bus0 got=%h want=%h", {bus.mem_address, bus.mem_write_data}, {base, data[7:0]}); end
        stalls = 1;
        for (int i = 1; i < VB; i++) begin
            @(negedge clk); clr(); if (use_junk) junk(); #1;
            ea = base + 16'(i);
            total++; if ({bus.mem_address, bus.mem_write_data} !== {ea, data[8*i +: 8]}) begin bad++; $display("FAIL vs_bus%0d got=%h want=%h", i, {bus.mem_address, bus.mem_write_data}, {ea, data[8*i +: 8]}); end
            total++; if ({bus.mem_write_enable, stall, done_m} !== {1'b1, i != VB - 1, i == VB - 1}) begin bad++; $display("FAIL vs_hs%0d got=%b want=%b", i, {bus.mem_write_enable, stall, done_m}, {1'b1, i != VB - 1, i == VB - 1}); end
            if (stall === 1'b1) stalls++;
        end
        for (int i = 0; i < VB; i++) ref_mem[16'(base + 16'(i))] = data[8*i +: 8];
        last_v = base;
        total++; if (stalls !== VB - 1) begin bad++; $display("FAIL vs_stalls got=%0d want=%0d", stalls, VB - 1); end
        @(negedge clk); clr(); #1;
        total++; if ({done_m, bus.mem_write_enable, stall} !== 3'b000) begin bad++; $display("FAIL vs_after got=%b want=000", {done_m, bus.mem_write_enable, stall}); end
    endtask

    task automatic test_vector_load(input logic [15:0] base, input logic [1:0] extra);
        logic [VW-1:0] e;
        logic [15:0] ea;
        for (int i = 0; i < VB; i++) e[8*i +: 8] = ref_mem[16'(base + 16'(i))];
        @(negedge clk); clr(); lv = 1'b1; {ls, wa} = extra; src_a = base; src_b = 16'($urandom); #1;
        total++; if (bus.mem_address !== base) begin bad++; $display("FAIL vl_addr0 got=%h want=%h", bus.mem_address, base); end
        total++; if ({stall, done_m, bus.mem_write_enable, aerr} !== 4'b1000) begin bad++; $display("FAIL vl_c0 got=%b want=1000", {stall, done_m, bus.mem_write_enable, aerr}); end
        for (int i = 1; i < VB; i++) begin
            @(negedge clk); junk(); #1;
            ea = base + 16'(i);
            total++; if (bus.mem_address !== ea) begin bad++; $display("FAIL vl_addr%0d got=%h want=%h", i, bus.mem_address, ea); end
            total++; if ({stall, done_m, bus.mem_write_enable} !== 3'b100) begin bad++; $display("FAIL vl_hs%0d got=%b want=100", i, {stall, done_m, bus.mem_write_enable}); end
            total++; if (vld !== exp_vl) begin bad++; $display("FAIL vl_partial%0d got=%h want=%h", i, vld, exp_vl); end
        end
        @(negedge clk); junk(); #1;
        total++; if ({stall, done_m, bus.mem_write_enable} !== 3'b010) begin bad++; $display("FAIL vl_last got=%b want=010", {stall, done_m, bus.mem_write_enable}); end
        total++; if (vld !== exp_vl) begin bad++; $display("FAIL vl_lasthold got=%h want=%h", vld, exp_vl); end
        @(negedge clk); clr(); #1;
        total++; if (vld !== e) begin bad++; $display("FAIL vl_data got=%h want=%h", vld, e); end
        total++; if (done_m !== 1'b0) begin bad++; $display("FAIL vl_done2 got=%0b want=0", done_m); end
        exp_vl = e;
    endtask

    task automatic test_directed();
        logic [VW-1:0] d;
        logic [VW-1:0] want;
        test_scalar_store(16'h0040, 16'h00A5, 1'b0);
        test_scalar_store(16'h0010, 16'h003C, 1'b0);
        test_scalar_load(16'h0010);
        total++; if (ld !== 8'h3C) begin bad++; $display("FAIL dir_sl got=%h want=3c", ld); end
        for (int i = 0; i < VB; i++) d[8*i +: 8] = 8'(i);
        test_vector_store(16'h0100, d, 3'b000, 1'b0);
        for (int i = 0; i < VB; i++) d[8*i +: 8] = 8'(i + 8'h80);
        test_vector_store(16'h0200, d, 3'b000, 1'b1);
        test_vector_load(16'h0200, 2'b00);
        want = 128'h8F8E8D8C8B8A89888786858483828180;
        total++; if (vld !== want) begin bad++; $display("FAIL dir_vl got=%h want=%h", vld, want); end
    endtask

    task automatic test_priority();
        logic [VW-1:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        test_vector_store(16'h0400, d, 3'b111, 1'b1);
        test_vector_load(16'h0400, 2'b11);
        test_scalar_store(16'h0400, 16'($urandom), 1'b1);
        test_scalar_load(16'h0400);
    endtask

    task automatic test_reset_abort();
        logic [VW-1:0] d;
        test_scalar_store(16'h0307, 16'h005A, 1'b0);
        d = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk); clr(); wb = 1'b1; src_a = 16'h0300; vsrc_b = d;
        for (int i = 1; i < 7; i++) begin
            @(negedge clk); clr(); #1;
            total++; if (bus.mem_address !== 16'h0300 + 16'(i)) begin bad++; $display("FAIL ab_addr%0d got=%h want=%h", i, bus.mem_address, 16'h0300 + 16'(i)); end
        end
        for (int i = 0; i < 7; i++) ref_mem[16'h0300 + 16'(i)] = d[8*i +: 8];
        @(negedge clk); reset = 1'b1; #1;
        total++; if ({bus.mem_write_enable, done_m} !== 2'b00) begin bad++; $display("FAIL ab_rst got=%b want=00", {bus.mem_write_enable, done_m}); end
        @(negedge clk); reset = 1'b0; #1;
        total++; if ({stall, done_m, bus.mem_write_enable} !== 3'b000) begin bad++; $display("FAIL ab_idle got=%b want=000", {stall, done_m, bus.mem_write_enable}); end
        total++; if (bus.mem_address !== 16'h0000) begin bad++; $display("FAIL ab_addr got=%h want=0000", bus.mem_address); end
        total++; if ({ld, vld} !== '0) begin bad++; $display("FAIL ab_regs got=%h want=0", {ld, vld}); end
        exp_ld = 8'h00; exp_vl = '0;
        @(negedge clk); #1;
        total++; if ({stall, done_m, bus.mem_write_enable} !== 3'b000) begin bad++; $display("FAIL ab_idle2 got=%b want=000", {stall, done_m, bus.mem_write_enable}); end
        test_scalar_load(16'h0307);
        test_scalar_load(16'h0306);
    endtask

    task automatic test_boundary();
        logic [VW-1:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
`ifdef VMEM_ADDR_CHECK_EN
        @(negedge clk); clr(); lv = 1'b1; src_a = 16'hFFF8; #1;
        total++; if ({aerr, stall, done_m, bus.mem_write_enable} !== 4'b1000) begin bad++; $display("FAIL bd_vl got=%b want=1000", {aerr, stall, done_m, bus.mem_write_enable}); end
        @(negedge clk); clr(); wb = 1'b1; src_a = 16'hFFF1; vsrc_b = d; #1;
        total++; if ({aerr, stall, done_m, bus.mem_write_enable} !== 4'b1000) begin bad++; $display("FAIL bd_vs got=%b want=1000", {aerr, stall, done_m, bus.mem_write_enable}); end
        @(negedge clk); clr(); #1;
        total++; if ({aerr, stall, done_m} !== 3'b000) begin bad++; $display("FAIL bd_after got=%b want=000", {aerr, stall, done_m}); end
        test_vector_store(16'hFFF0, d, 3'b000, 1'b0);
        test_vector_load(16'hFFF0, 2'b00);
`else
        test_vector_store(16'hFFF8, d, 3'b000, 1'b0);
        test_vector_load(16'hFFF8, 2'b00);
`endif
    endtask

    task automatic test_random();
        int kind;
        for (int n = 0; n < 14; n++) begin
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: test_scalar_store(16'($urandom), 16'($urandom), 1'($urandom));
                1: test_scalar_load(last_s);
                2: test_vector_store(rand_base(), {$urandom, $urandom, $urandom, $urandom}, 3'($urandom), 1'b1);
                default: test_vector_load(last_v, 2'($urandom));
            endcase
        end
    endtask

    initial begin
        reset = 1'b1;
        clr();
        test_reset();
        test_directed();
        test_priority();
        test_boundary();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vector_memory_sequencer.md
VECTOR_MEMORY_SEQUENCER -- requirements
Module: vector_memory_sequencer

Interface
REQ-001 SHALL have parameter VECTOR_BYTES, default 16, meaning bytes per vector access (vector width = 8*VECTOR_BYTES).
REQ-002 SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports write_memory_enable_a_memory, write_memory_enable_b_memory  in  1 each  scalar-store / vector-store request from the memory stage.
REQ-005 SHALL have ports load_scalar_memory, load_vector_memory  in  1 each  scalar-load / vector-load request.
REQ-006 SHALL have ports srcA_memory  in  16  base address; srcB_memory  in  16  scalar store data, low 8 bits used; vector_srcB_memory  in  128  vector store data.
REQ-007 SHALL have ports mem_address  out  16; mem_write_data  out  8; mem_write_enable  out  1; mem_read_data  in  8, valid one cycle after mem_address is presented.
REQ-008 SHALL have ports stall  out  1  pipeline hold; done_memory  out  1  completion pulse; load_data_memory  out  8; vector_load_data_memory  out  128; addr_error  out  1.

Function
REQ-009 SHALL implement FSM states IDLE, SREAD, VSTORE, VLOAD, VLAST; requests SHALL be sampled only in IDLE.
REQ-010 SHALL resolve simultaneous requests by priority: vector store > vector load > scalar store > scalar load, and SHALL ignore the lower-priority ones.
REQ-011 Scalar store in IDLE SHALL drive mem_write_enable=1, mem_address=srcA, mem_write_data=srcB[7:0] in the same cycle, with stall=0 and done_memory=1, and SHALL stay in IDLE.
REQ-012 Scalar load in IDLE SHALL drive mem_address=srcA and stall=1, then go to SREAD.
REQ-013 SREAD SHALL register mem_read_data into load_data_memory, drive stall=0 and done_memory=1, then return to IDLE. Latency is 2 cycles.
REQ-014 Vector store in IDLE SHALL latch the address and vector data, write byte 0 (bits [7:0]) at srcA with stall=1, then go to VSTORE with counter=1.
REQ-015 VSTORE SHALL write byte i (bits [8i+7:8i]) at base+i and increment the counter. At i=VECTOR_BYTES-1 it SHALL drive stall=0 and done_memory=1 and return to IDLE. Total is VECTOR_BYTES cycles.
REQ-016 Vector load in IDLE SHALL issue address base+0 with stall=1, then go to VLOAD with counter=1.
REQ-017 VLOAD SHALL issue base+i and capture mem_read_data into buffer byte i-1. After issuing i=VECTOR_BYTES-1 it SHALL go to VLAST.
REQ-018 VLAST SHALL capture the final byte and update vector_load_data_memory with all bytes at once at the end of that cycle. It SHALL drive stall=0 and done_memory=1. Total is VECTOR_BYTES+1 cycles.
REQ-019 vector_load_data_memory and load_data_memory SHALL hold their value until the next completing load of the same kind; partial results SHALL never be visible.
REQ-020 Address arithmetic SHALL be 16-bit modulo 2^16, subject to REQ-026.
REQ-021 stall SHALL be 1 in every non-final busy cycle and 0 in the final cycle and in idle cycles. mem_write_enable SHALL be 0 outside store cycles.
REQ-022 done_memory SHALL be a single-cycle pulse per completed request.

Reset
REQ-023 Reset high SHALL force mem_write_enable=0 in the same cycle and return the FSM to IDLE at the next edge, including mid-operation; the aborted access SHALL NOT complete or pulse done_memory.
REQ-024 After reset, all registered outputs SHALL be 0: load_data_memory=0, vector_load_data_memory=0, done_memory=0, addr_error=0, counter=0. With requests low, stall=0, mem_address=0 and mem_write_data=0.

Configuration
REQ-025 SHALL support the macro VMEM_ADDR_CHECK_EN.
REQ-026 With VMEM_ADDR_CHECK_EN defined, a vector request with srcA > 16'hFFFF-(VECTOR_BYTES-1) SHALL be rejected in IDLE: no memory write, no state change, stall=0, addr_error=1 for that cycle, done_memory=0.
REQ-027 Without VMEM_ADDR_CHECK_EN, addr_error SHALL be tied to 0 and addresses SHALL wrap per REQ-020.

Verification
REQ-028 Scalar store srcA=16'h0040, srcB=16'h00A5 -> same cycle: mem_write_enable=1, addr 0x0040, data 0xA5, stall=0, done_memory=1.
REQ-029 Scalar load srcA=0x0010, memory holds 0x3C -> stall=1 for 1 cycle; load_data_memory=0x3C the cycle after SREAD.
REQ-030 Vector store srcA=0x0100, data=0x0F0E..0100 -> 16 consecutive writes to 0x0100..0x010F with bytes 0x00..0x0F; stall high for 15 cycles.
REQ-031 Vector load from 0x0200 where mem[0x0200+i]=i+0x80 -> after 17 cycles vector_load_data_memory=0x8F8E..8180; no intermediate change.
REQ-032 Vector store and scalar load asserted together -> only the vector store executes; reset at counter=7 -> no further writes, FSM in IDLE, stall=0.
REQ-033 Vector load at srcA=0xFFF8: with VMEM_ADDR_CHECK_EN -> addr_error=1, no access; without it -> addresses 0xFFF8..0xFFFF, then 0x0000..0x0007.
